uart_tx_cfg: RTL

//  Runtime-configurable UART transmitter with an internal byte FIFO. Successor to the fixed 8N1 transmitter.

---
 rtl/uart_tx_cfg_if.sv | 19 +
 rtl/uart_tx_cfg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg_if.sv
// AXI-Stream byte channel feeding the configurable UART transmitter.
// The byte source drives data/valid; the transmitter returns ready.
interface uart_tx_cfg_if;
    logic [7:0] s_axis_data;
    logic       s_axis_valid;
    logic       s_axis_ready;

    modport master (
        output s_axis_data,
        output s_axis_valid,
        input  s_axis_ready
    );

    modport slave (
        input  s_axis_data,
        input  s_axis_valid,
        output s_axis_ready
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, none/odd/even parity, 1/2 stop bits)
// with a byte FIFO in front of it, so that queued frames follow each other without an idle gap.
module uart_tx_cfg #(
    parameter int unsigned DivWidth  = 16,
    parameter int unsigned FifoDepth = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DivWidth-1:0]         i_cfg_baud_div,
    input  logic [1:0]                  i_cfg_data_bits,
    input  logic [1:0]                  i_cfg_parity,
    input  logic                        i_cfg_stop2,
    uart_tx_cfg_if.slave                s_axis,
    output logic                        o_tx,
    output logic                        o_tx_idle,
    output logic                        o_tx_done,
    output logic [$clog2(FifoDepth):0]  o_fifo_level
);

    localparam int unsigned PtrWidth = $clog2(FifoDepth);
    localparam int unsigned LvlWidth = $clog2(FifoDepth) + 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                r_state, w_state_next;
    logic [7:0]            r_mem [FifoDepth];
    logic [PtrWidth-1:0]   r_wptr, r_rptr;
    logic [LvlWidth-1:0]   r_level, w_level_next;
    logic                  r_ready;
    logic                  w_push, w_pop;
    logic [DivWidth-1:0]   r_div, r_cnt, w_cnt_next, w_div_cfg;
    logic [2:0]            r_bit, w_bit_next, r_last_bit;
    logic [7:0]            r_data, w_mask, w_data_masked;
    logic                  r_par_en, r_par_bit, r_stop2;
    logic                  r_tx, w_tx, r_done, w_done, r_idle;
    logic                  w_bit_end;

    assign w_push        = s_axis.s_axis_valid & r_ready;
    assign w_level_next  = r_level + LvlWidth'(w_push) - LvlWidth'(w_pop);
    assign w_div_cfg     = (i_cfg_baud_div < DivWidth'(2)) ? DivWidth'(2) : i_cfg_baud_div;
    assign w_mask        = 8'hFF >> (2'd3 - i_cfg_data_bits);
    assign w_data_masked = r_mem[r_rptr] & w_mask;
    assign w_bit_end     = (r_cnt == r_div - DivWidth'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_level <= w_level_next;
            r_ready <= (w_level_next != LvlWidth'(FifoDepth));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= s_axis.s_axis_data;
    end

    // Frame settings are captured with the byte so config changes only affect later frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_div      <= DivWidth'(2);
            r_last_bit <= 3'd7;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
        end else if (w_pop) begin
            r_data     <= w_data_masked;
            r_div      <= w_div_cfg;
            r_last_bit <= {1'b1, i_cfg_data_bits};
            r_par_en   <= ^i_cfg_parity;
            r_par_bit  <= (^w_data_masked) ^ (i_cfg_parity == 2'b01);
            r_stop2    <= i_cfg_stop2;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + DivWidth'(1);
        w_bit_next   = r_bit;
        w_pop        = 1'b0;
        w_tx         = 1'b1;
        w_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_next = '0;
                if (r_level != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = StStart;
                end
            end
            StStart: begin
                w_tx = 1'b0;
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = StData;
                end
            end
            StData: begin
                w_tx = r_data[r_bit];
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_bit == r_last_bit) begin
                        w_bit_next   = '0;
                        w_state_next = r_par_en ? StParity : StStop;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            StParity: begin
                w_tx = r_par_bit;
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_state_next = StStop;
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_stop2 && (r_bit == 3'd0)) begin
                        w_bit_next = 3'd1;
                    end else begin
                        w_done     = 1'b1;
                        w_bit_next = '0;
                        // Chain straight into the next queued byte.
                        if (r_level != '0) begin
                            w_pop        = 1'b1;
                            w_state_next = StStart;
                        end else begin
                            w_state_next = StIdle;
                        end
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Line, done and idle are registered from the current state, so they trail it by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
            r_idle  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx;
            r_done  <= w_done;
            r_idle  <= (r_state == StIdle) && (r_level == '0);
        end
    end

    assign s_axis.s_axis_ready = r_ready;
    assign o_tx                = r_tx;
    assign o_tx_done           = r_done;
    assign o_tx_idle           = r_idle;
    assign o_fifo_level        = r_level;

endmodule
